// File: rtl/fetch_stage.sv
// fetch_stage
// -----------------------------------------------------------------------------
// Instruction fetch stage of the MIPS-DLX pipeline. It owns the program
// counter and fetches instructions from instruction memory over a req/ack
// handshake. It hands each word and its PC+4 to the IF/ID latch with a
// one-cycle latch_enable pulse.
//
// Handshake (imem_req / imem_ack):
//   imem_req is high while a fetch is outstanding, and imem_addr is held
//   constant for the whole request. The request completes on the first
//   rising edge that samples imem_ack high while imem_req is high. That can
//   be the first cycle of the request. imem_ack is ignored while imem_req is
//   low. A request that is in flight when a branch arrives is drained to
//   completion at its original address, and its data is then dropped.
//
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous, active-low reset
//   stall          : hazard-unit stall; holds a fetched word back from delivery
//   branch_taken   : one-cycle redirect request
//   branch_target  : redirect PC, sampled with branch_taken
//   imem_req       : fetch request to instruction memory
//   imem_addr      : fetch address
//   imem_ack       : memory completion strobe
//   imem_data      : instruction word, valid with imem_ack
//   instr_out      : instruction to the IF/ID latch
//   pc_plus4_out   : PC+4 of instr_out
//   latch_enable   : single-cycle load pulse for the IF/ID latch
//   state_dbg      : current FSM state (START=0, FETCH=1, HOLD=2, DRAIN=3)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                  BUS_SIZE = 32,
  parameter logic [BUS_SIZE-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [BUS_SIZE-1:0] branch_target,
  output logic                imem_req,
  output logic [BUS_SIZE-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [BUS_SIZE-1:0] imem_data,
  output logic [BUS_SIZE-1:0] instr_out,
  output logic [BUS_SIZE-1:0] pc_plus4_out,
  output logic                latch_enable,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [BUS_SIZE-1:0] PC_STEP = BUS_SIZE'(4);

  logic [1:0]          state;
  logic [BUS_SIZE-1:0] pc;
  logic [BUS_SIZE-1:0] drain_addr;
  logic [BUS_SIZE-1:0] pc_inc;

  // Wraps modulo 2^BUS_SIZE. No alignment checking is done.
  assign pc_inc = pc + PC_STEP;

  // The request lines are decoded from the state register. Because of this,
  // an asynchronous reset drops imem_req immediately.
  assign imem_req  = (state == S_FETCH) || (state == S_DRAIN);
  assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_START;
      pc           <= RESET_PC;
      drain_addr   <= RESET_PC;
      instr_out    <= '0;
      pc_plus4_out <= '0;
      latch_enable <= 1'b0;
    end else begin
      // latch_enable defaults low every cycle, so it can only ever be a
      // single-cycle pulse.
      latch_enable <= 1'b0;
      case (state)
        S_START: begin
          state <= S_FETCH;
          if (branch_taken) pc <= branch_target;
        end
        S_FETCH: begin
          if (branch_taken) begin
            // A branch beats both delivery and stall. If the fetch has not
            // completed yet, remember its address so the request can be
            // drained without imem_addr moving.
            pc <= branch_target;
            if (!imem_ack) begin
              drain_addr <= pc;
              state      <= S_DRAIN;
            end
          end else if (imem_ack) begin
            instr_out    <= imem_data;
            pc_plus4_out <= pc_inc;
            pc           <= pc_inc;
            if (stall) state <= S_HOLD;
            else       latch_enable <= 1'b1;
          end
        end
        S_HOLD: begin
          // The fetched word stays parked in instr_out until release.
          if (branch_taken) begin
            pc    <= branch_target;
            state <= S_FETCH;
          end else if (!stall) begin
            latch_enable <= 1'b1;
            state        <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // The latest branch target wins. The drained data is dropped.
          if (branch_taken) pc <= branch_target;
          if (imem_ack) state <= S_FETCH;
        end
        default: state <= S_START;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the MIPS-DLX pipeline, directly upstream of the IF/ID `latch` instance. It owns the program counter and runs a req/ack handshake with instruction memory. It delivers each fetched instruction and its PC+4 to the IF/ID latch with a one-cycle `latch_enable` pulse. It holds a fetched word while the hazard unit stalls and redirects on taken branches, discarding any in-flight fetch.

## Interface
- `BUS_SIZE`, 32, width of PC, address and instruction buses
- `RESET_PC`, 0, PC value loaded on reset
- `clk` input 1: single clock; all state changes on the rising edge
- `reset` input 1: asynchronous, active-low; clears all state immediately when low
- `stall` input 1: from the hazard unit; when high, a completed fetch is not delivered
- `branch_taken` input 1: redirect request, valid for one cycle
- `branch_target` input BUS_SIZE: new PC, sampled when `branch_taken` is high
- `imem_req` output 1: fetch request to instruction memory
- `imem_addr` output BUS_SIZE: fetch address; stable while `imem_req` is high
- `imem_ack` input 1: memory completes the request this cycle; meaningful only while `imem_req` is high
- `imem_data` input BUS_SIZE: instruction word, valid when `imem_ack` is high
- `instr_out` output BUS_SIZE: instruction to the IF/ID latch `data_in`
- `pc_plus4_out` output BUS_SIZE: PC+4 of `instr_out`
- `latch_enable` output 1: registered pulse that loads the IF/ID latch

## Operation
- State registers: `pc`, `drain_addr`, and FSM states START, FETCH, HOLD, DRAIN.
- **Reset values:**
  - state START
  - `pc` = `drain_addr` = RESET_PC
  - `instr_out` = 0, `pc_plus4_out` = 0
  - `latch_enable` = 0
  - `imem_req` = 0
  - `imem_addr` = RESET_PC
- **Outputs by state:**
  - `imem_req` = 1 in FETCH and DRAIN, 0 otherwise.
  - `imem_addr` = `drain_addr` in DRAIN, `pc` otherwise.
- **START:**
  - Goes to FETCH on the next edge.
  - If `branch_taken` is high, `pc` <= `branch_target`.
- **FETCH**, evaluated in priority order:
  - `branch_taken` and `imem_ack`: discard `imem_data`, `pc` <= `branch_target`, stay in FETCH.
  - `branch_taken` and no ack: `drain_addr` <= `pc`, `pc` <= `branch_target`, go to DRAIN.
  - `imem_ack` and `!stall`: `instr_out` <= `imem_data`, `pc_plus4_out` <= `pc`+4, `pc` <= `pc`+4, `latch_enable` <= 1, stay in FETCH.
  - `imem_ack` and `stall`: same captures, but `latch_enable` <= 0; go to HOLD.
  - No ack: hold all state.
- **HOLD** (word parked in `instr_out`):
  - `branch_taken`: discard the parked word, `pc` <= `branch_target`, go to FETCH; no pulse.
  - `!stall`: `latch_enable` <= 1, go to FETCH.
  - Otherwise: stay in HOLD.
- **DRAIN** (squash the outstanding request):
  - Keep `imem_addr` = `drain_addr` until ack.
  - On `imem_ack`: discard the data, go to FETCH.
  - `branch_taken` during DRAIN: `pc` <= the newer `branch_target`, stay in DRAIN (or leave it if the ack arrives in the same cycle).
- **Pulse rule:** `latch_enable` is 0 in every cycle not explicitly set to 1 above, so it is always a single-cycle pulse.
- **Arithmetic:** `pc`+4 is modulo 2^BUS_SIZE, so 0xFFFFFFFC wraps to 0x00000000. No alignment checking.
- **Reset mid-operation:** any state returns to START asynchronously. Any outstanding memory request is abandoned and `imem_req` drops immediately.

## Timing
- The first request is issued one cycle after `reset` deasserts (the START cycle).
- Latency: `latch_enable` and the new `instr_out`/`pc_plus4_out` appear on the edge that samples `imem_ack`. The IF/ID latch is therefore transparent to the new word in the following cycle.
- Throughput: one instruction per cycle when memory acks in the same cycle as the request.
- `imem_ack` may arrive in the first cycle `imem_req` is high.
- While `imem_req` is high, `imem_addr` never changes until ack. A branch arriving during a request is honoured only after the drain completes.
- `stall` is sampled only on ack cycles in FETCH and in every HOLD cycle.
- A branch takes priority over `stall` and over delivery in the same cycle.
- Branch redirect latency:
  - Redirected request visible the next cycle if no fetch is outstanding.
  - Otherwise visible one cycle after the drain ack.

## Test plan
- **Reset and streaming:** release reset with memory always acking. `imem_addr` goes 0x0, 0x4, 0x8. `latch_enable` is high every cycle from the first ack. `pc_plus4_out` goes 0x4, 0x8, 0xC.
- **Wait states:** ack 2 cycles after each request.
  - `imem_addr` holds for 3 cycles.
  - `latch_enable` pulses once per word.
  - `pc_plus4_out` advances by 4 per pulse.
- **Stall on ack:** `stall`=1 for 3 cycles starting at the ack of address 0x8.
  - FSM sits in HOLD, `imem_req`=0, `instr_out` keeps word@0x8, no pulse.
  - Pulse occurs on the edge after `stall` falls.
  - Next request is 0xC.
- **Branch with outstanding fetch:** `branch_taken`, target 0x100, while a request to 0x10 is unacked.
  - `imem_addr` stays 0x10 until ack; that data is dropped with no pulse.
  - Next request is 0x100; its word delivers `pc_plus4_out`=0x104.
- **Branch in HOLD, and branch beating stall:**
  - Branch to 0x200 during HOLD: the parked word is never pulsed; the next fetch is 0x200.
  - Branch coincident with ack+stall: HOLD is not entered.
- **Async reset mid-DRAIN and PC wrap:**
  - Reset asserted mid-DRAIN between edges: `imem_req`=0 and `latch_enable`=0 immediately.
  - PC wrap: with RESET_PC=0xFFFFFFFC, the first delivered `pc_plus4_out`=0x0 and the next `imem_addr`=0x0.
